// File: rtl/cache_mem_if.sv
// Controller-facing handshake bundle of the cache main-memory stage: block fill
// requests and dirty-victim write-back pushes.
interface cache_mem_if #(
   parameter int ADDR_W = 14
);
   logic              fill_valid;
   logic [ADDR_W-1:0] fill_addr;
   logic              fill_ready;
   logic              fill_done;
   logic              wb_valid;
   logic [ADDR_W-1:0] wb_addr;
   logic              wb_ready;

   modport master (
      output fill_valid, fill_addr, wb_valid, wb_addr,
      input  fill_ready, fill_done, wb_ready
   );

   modport slave (
      input  fill_valid, fill_addr, wb_valid, wb_addr,
      output fill_ready, fill_done, wb_ready
   );
endinterface

// File: rtl/cache_mem_interface.sv
// Main-memory stage behind the cache controller: fills, write-back FIFO, latency model, stats.
// Optional feature macro WB_COALESCE_EN: absorb write-backs that duplicate a buffered block.
module cache_mem_interface #(
   parameter int BLK_ADDR_W  = 14,
   parameter int WB_DEPTH    = 4,
   parameter int MEM_LATENCY = 8,
   parameter int CNT_W       = 14
) (
   input  logic                      clk,
   input  logic                      reset,
   cache_mem_if.slave                bus,
   output logic                      mem_busy,
   output logic [$clog2(WB_DEPTH):0] buf_level,
   output logic [CNT_W-1:0]          fill_count,
   output logic [CNT_W-1:0]          wb_count,
   output logic [CNT_W-1:0]          fwd_count
);
   localparam int PTR_W = $clog2(WB_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int LAT_W = $clog2(MEM_LATENCY);
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY - 1);
   localparam logic [LAT_W-1:0] LAT_ZERO = LAT_W'(0);
   localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(WB_DEPTH);
   localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(0);
   localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
   localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      FWD  = 2'd2,
      WB   = 2'd3
   } state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   state_t                  state_r, state_nxt_s;
   logic [LAT_W-1:0]        cnt_r, cnt_nxt_s;
   logic [PTR_W-1:0]        head_r, tail_r;
   logic [LVL_W-1:0]        level_r, level_nxt_s;
   logic [BLK_ADDR_W-1:0]   buf_mem_r [WB_DEPTH];
   logic [CNT_W-1:0]        fill_count_r, wb_count_r, fwd_count_r;
   logic full_s, empty_s, fill_ready_s, fill_acc_s, pop_s;
   logic buf_hit_s, wb_dup_s, wb_ready_s, wb_write_s, fwd_hit_s;
   logic access_end_s;

   assign full_s       = (level_r == LVL_FULL);
   assign empty_s      = (level_r == LVL_ZERO);
   assign fill_ready_s = (state_r == IDLE) && !full_s;
   assign fill_acc_s   = bus.fill_valid && fill_ready_s;
   assign pop_s        = (state_r == IDLE) && !fill_acc_s && !empty_s;
   assign access_end_s = (cnt_r == LAT_ZERO);

   // Address match against live buffer entries; the head being popped is not a coalesce target.
   always_comb begin
      buf_hit_s = 1'b0;
      wb_dup_s  = 1'b0;
      for (int i = 0; i < WB_DEPTH; i++) begin
         if ({1'b0, PTR_W'(i) - head_r} < level_r) begin
            if (buf_mem_r[i] == bus.fill_addr) begin
               buf_hit_s = 1'b1;
            end else begin
               buf_hit_s = buf_hit_s;
            end
            if ((buf_mem_r[i] == bus.wb_addr) && !(pop_s && (PTR_W'(i) == head_r))) begin
               wb_dup_s = 1'b1;
            end else begin
               wb_dup_s = wb_dup_s;
            end
         end else begin
            buf_hit_s = buf_hit_s;
            wb_dup_s  = wb_dup_s;
         end
      end
   end

`ifdef WB_COALESCE_EN
   assign wb_ready_s = !full_s || wb_dup_s;
   assign wb_write_s = bus.wb_valid && wb_ready_s && !wb_dup_s;
`else
   assign wb_ready_s = !full_s;
   assign wb_write_s = bus.wb_valid && wb_ready_s;
`endif

   assign fwd_hit_s = buf_hit_s ||
                      (bus.wb_valid && wb_ready_s && (bus.wb_addr == bus.fill_addr));

   // Next-state and latency counter
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (fill_acc_s) begin
               state_nxt_s = fwd_hit_s ? FWD : FILL;
               cnt_nxt_s   = LAT_LOAD;
            end else if (pop_s) begin
               state_nxt_s = WB;
               cnt_nxt_s   = LAT_LOAD;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         FILL, WB: begin
            if (access_end_s) begin
               state_nxt_s = IDLE;
            end else begin
               cnt_nxt_s = cnt_r - LAT_ONE;
            end
         end
         FWD:     state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Occupancy: a push and a pop on the same edge cancel out
   always_comb begin
      case ({wb_write_s, pop_s})
         2'b10:   level_nxt_s = level_r + LVL_ONE;
         2'b01:   level_nxt_s = level_r - LVL_ONE;
         default: level_nxt_s = level_r;
      endcase
   end

   // FSM, FIFO pointers and statistics
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         cnt_r        <= LAT_ZERO;
         head_r       <= PTR_ZERO;
         tail_r       <= PTR_ZERO;
         level_r      <= LVL_ZERO;
         fill_count_r <= CNT_ZERO;
         wb_count_r   <= CNT_ZERO;
         fwd_count_r  <= CNT_ZERO;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         level_r <= level_nxt_s;
         if (wb_write_s) tail_r <= tail_r + PTR_ONE;
         if (pop_s)      head_r <= head_r + PTR_ONE;
         if ((state_r == FILL) && access_end_s) fill_count_r <= sat_inc(fill_count_r);
         if ((state_r == WB) && access_end_s)   wb_count_r   <= sat_inc(wb_count_r);
         if (state_r == FWD)                    fwd_count_r  <= sat_inc(fwd_count_r);
      end
   end

   // Buffer storage; only entries inside [head, head+level) are ever read
   always_ff @(posedge clk) begin
      if (wb_write_s) buf_mem_r[tail_r] <= bus.wb_addr;
   end

   assign bus.fill_ready = fill_ready_s;
   assign bus.wb_ready   = wb_ready_s;
   assign bus.fill_done  = (state_r == FWD) || ((state_r == FILL) && access_end_s);
   assign mem_busy       = (state_r == FILL) || (state_r == WB);
   assign buf_level      = level_r;
   assign fill_count     = fill_count_r;
   assign wb_count       = wb_count_r;
   assign fwd_count      = fwd_count_r;
endmodule

// File: tb/tb_cache_mem_interface.sv
// Directed bench for cache_mem_interface; a second small instance (CNT_W=3) exercises
// counter saturation. Expected values follow WB_COALESCE_EN when it is defined.
module tb_cache_mem_interface;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cache_mem_if #(.ADDR_W(14)) bus ();
   cache_mem_if #(.ADDR_W(14)) sbus ();

   logic        mem_busy;
   logic [2:0]  buf_level;
   logic [13:0] fill_count, wb_count, fwd_count;
   logic        s_mem_busy;
   logic [1:0]  s_buf_level;
   logic [2:0]  s_fill_count, s_wb_count, s_fwd_count;

   int n_vec = 0;
   int n_err = 0;
   int exp_wb = 0;

   cache_mem_interface #(.BLK_ADDR_W(14), .WB_DEPTH(4), .MEM_LATENCY(8), .CNT_W(14)) dut (
      .clk(clk), .reset(reset), .bus(bus), .mem_busy(mem_busy), .buf_level(buf_level),
      .fill_count(fill_count), .wb_count(wb_count), .fwd_count(fwd_count)
   );

   cache_mem_interface #(.BLK_ADDR_W(14), .WB_DEPTH(2), .MEM_LATENCY(2), .CNT_W(3)) dut_sat (
      .clk(clk), .reset(reset), .bus(sbus), .mem_busy(s_mem_busy), .buf_level(s_buf_level),
      .fill_count(s_fill_count), .wb_count(s_wb_count), .fwd_count(s_fwd_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.fill_valid = 1'b0;  bus.fill_addr = 14'h0;  bus.wb_valid = 1'b0;  bus.wb_addr = 14'h0;
      sbus.fill_valid = 1'b0; sbus.fill_addr = 14'h0; sbus.wb_valid = 1'b0; sbus.wb_addr = 14'h0;
      tick(2);
      chk("rst_fill_ready", bus.fill_ready, 1);
      chk("rst_wb_ready", bus.wb_ready, 1);
      chk("rst_fill_done", bus.fill_done, 0);
      chk("rst_mem_busy", mem_busy, 0);
      chk("rst_buf_level", buf_level, 0);
      chk("rst_counts", {fill_count, wb_count}, 0);
      reset = 1'b0;
      tick(1);

      // plain fill: done exactly 8 cycles after acceptance
      bus.fill_addr = 14'h0123; bus.fill_valid = 1'b1;
      chk("s1_ready_idle", bus.fill_ready, 1);
      tick(1);
      bus.fill_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         chk("s1_ready_busy", bus.fill_ready, 0);
         chk("s1_done", bus.fill_done, (k == 8));
         tick(1);
      end
      chk("s1_ready_after", bus.fill_ready, 1);
      chk("s1_fill_count", fill_count, 1);
      chk("s1_busy_after", mem_busy, 0);

      // reset in cycle 4 of a fill abandons it
      bus.fill_addr = 14'h0123; bus.fill_valid = 1'b1;
      tick(1);
      bus.fill_valid = 1'b0;
      tick(3);
      chk("s2_busy_before", mem_busy, 1);
      reset = 1'b1;
      #2;
      chk("s2_busy", mem_busy, 0);
      chk("s2_ready", bus.fill_ready, 1);
      chk("s2_fill_count", fill_count, 0);
      tick(1);
      reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         chk("s2_no_done", bus.fill_done, 0);
         tick(1);
      end
      chk("s2_fill_count_after", fill_count, 0);

      // fill hits buffered write-back -> forward, entry still drains
      bus.wb_addr = 14'h0040; bus.wb_valid = 1'b1;
      tick(1);
      bus.wb_valid = 1'b0;
      bus.fill_addr = 14'h0040; bus.fill_valid = 1'b1;
      chk("s3_level_pre", buf_level, 1);
      tick(1);
      bus.fill_valid = 1'b0;
      chk("s3_fwd_done", bus.fill_done, 1);
      chk("s3_fwd_busy", mem_busy, 0);
      tick(1);
      chk("s3_fwd_count", fwd_count, 1);
      chk("s3_level", buf_level, 1);
      chk("s3_wb_count0", wb_count, 0);
      chk("s3_done_off", bus.fill_done, 0);
      tick(1);
      chk("s3_drain_busy", mem_busy, 1);
      chk("s3_drain_level", buf_level, 0);
      tick(7);
      chk("s3_wb_count_mid", wb_count, 0);
      tick(1);
      exp_wb = 1;
      chk("s3_wb_count", wb_count, exp_wb);
      chk("s3_idle", mem_busy, 0);

      // fill the buffer during a fill; full buffer drains before next fill
      bus.fill_addr = 14'h0500; bus.fill_valid = 1'b1;
      tick(1);
      bus.fill_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.wb_addr = 14'h0100 + 14'(i); bus.wb_valid = 1'b1;
         tick(1);
      end
      bus.wb_valid = 1'b0;
      bus.wb_addr = 14'h0200;
      chk("s4_full_level", buf_level, 4);
      chk("s4_wb_ready", bus.wb_ready, 0);
      bus.fill_addr = 14'h0999; bus.fill_valid = 1'b1;
      tick(4);
      chk("s4_idle_full_ready", bus.fill_ready, 0);
      chk("s4_idle_full_level", buf_level, 4);
      tick(1);
      chk("s4_drain_level", buf_level, 3);
      chk("s4_drain_busy", mem_busy, 1);
      chk("s4_drain_ready", bus.fill_ready, 0);
      tick(8);
      exp_wb = 2;
      chk("s4_head_drained", wb_count, exp_wb);
      chk("s4_fill_ready", bus.fill_ready, 1);
      tick(1);
      bus.fill_valid = 1'b0;
      tick(6);
      chk("s4_done_early", bus.fill_done, 0);
      tick(1);
      chk("s4_done", bus.fill_done, 1);
      tick(28);
      exp_wb = 5;
      chk("s4_wb_count", wb_count, exp_wb);
      chk("s4_level_empty", buf_level, 0);
      chk("s4_fill_count", fill_count, 2);

      // duplicate write-back pushed twice while memory is busy
      bus.fill_addr = 14'h0700; bus.fill_valid = 1'b1;
      tick(1);
      bus.fill_valid = 1'b0;
      bus.wb_addr = 14'h0010; bus.wb_valid = 1'b1;
      tick(2);
      bus.wb_valid = 1'b0;
`ifdef WB_COALESCE_EN
      chk("s5_dup_level", buf_level, 1);
      exp_wb = exp_wb + 1;
`else
      chk("s5_dup_level", buf_level, 2);
      exp_wb = exp_wb + 2;
`endif
      tick(30);
      chk("s5_wb_count", wb_count, exp_wb);
      chk("s5_level", buf_level, 0);
      chk("s5_fill_count", fill_count, 3);

      // fill matching a same-cycle write-back enqueue forwards
      bus.fill_addr = 14'h0222; bus.fill_valid = 1'b1;
      bus.wb_addr = 14'h0222;   bus.wb_valid = 1'b1;
      tick(1);
      bus.fill_valid = 1'b0; bus.wb_valid = 1'b0;
      chk("s6_fwd_done", bus.fill_done, 1);
      chk("s6_level", buf_level, 1);
      tick(1);
      chk("s6_fwd_count", fwd_count, 2);
      tick(9);
      exp_wb = exp_wb + 1;
      chk("s6_wb_count", wb_count, exp_wb);
      chk("s6_level_after", buf_level, 0);

      // saturation on the 3-bit instance: 7 fills reach all-ones, more must not wrap
      sbus.fill_addr = 14'h0005; sbus.fill_valid = 1'b1;
      tick(21);
      chk("s7_count_max", s_fill_count, 7);
      tick(9);
      chk("s7_count_sat", s_fill_count, 7);
      sbus.fill_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
